// File: rtl/mac_accumulator_pkg.sv
// mac_accumulator_pkg: shared FSM state encoding and default widths for the MAC accumulator
package mac_accumulator_pkg;
    localparam int ACC_W_DEF = 24;
    localparam int LEN_W_DEF = 8;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/mac_accumulator_if.sv
// mac_accumulator_if: product-in and result-out handshake channels
//   prod_valid/prod_ready/Prod : 16-bit product stream from the multiplier
//   acc_valid/acc_ready/Acc    : ACC_W-bit result toward writeback
//   slave modport = accumulator side, master modport = producer/consumer side
interface mac_accumulator_if
    import mac_accumulator_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
);
    logic             prod_valid;
    logic             prod_ready;
    logic [15:0]      Prod;
    logic             acc_valid;
    logic             acc_ready;
    logic [ACC_W-1:0] Acc;
    modport slave (input prod_valid, Prod, acc_ready, output prod_ready, acc_valid, Acc);
    modport master (output prod_valid, Prod, acc_ready, input prod_ready, acc_valid, Acc);
endinterface

// File: rtl/mac_accumulator_acc_adder.sv
// mac_accumulator_acc_adder: ACC_W-bit accumulate add with carry out and optional saturation
//   a     : current accumulator value
//   b     : 16-bit product, zero-extended
//   sum   : next accumulator value (wrapped, or all ones on carry when saturating)
//   carry : carry out of bit ACC_W-1
//   Macro MAC_ACCUMULATOR_SATURATE_EN selects saturation instead of wrap.
module mac_accumulator_acc_adder
    import mac_accumulator_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0] a,
    input  logic [15:0]      b,
    output logic [ACC_W-1:0] sum,
    output logic             carry
);
    logic [ACC_W:0] full;
    always_comb begin
        full  = {1'b0, a} + (ACC_W+1)'(b);
        carry = full[ACC_W];
`ifdef MAC_ACCUMULATOR_SATURATE_EN
        // once saturated, any nonzero add carries again and zero adds keep all ones
        sum   = carry ? '1 : full[ACC_W-1:0];
`else
        sum   = full[ACC_W-1:0];
`endif
    end
endmodule

// File: rtl/mac_accumulator.sv
// mac_accumulator: sums a programmed number of 16-bit products into a registered accumulator
//   clk, rst  : clock, synchronous active-high reset
//   start/len : begin an accumulation of len terms (sampled only in IDLE)
//   bus       : product input and result output handshakes (slave side)
//   busy      : high in ACCUM or DONE
//   overflow  : sticky per operation, carry out of ACC_W seen
//   Optional macro MAC_ACCUMULATOR_SATURATE_EN: saturate instead of wrap.
module mac_accumulator
    import mac_accumulator_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    mac_accumulator_if.slave bus,
    output logic             busy,
    output logic             overflow
);
    state_t           state, nxt;
    logic [ACC_W-1:0] acc, sum;
    logic [LEN_W-1:0] remaining;
    logic             carry, xfer;

    mac_accumulator_acc_adder #(.ACC_W(ACC_W)) u_add (
        .a     (acc),
        .b     (bus.Prod),
        .sum   (sum),
        .carry (carry)
    );

    assign xfer = (state == ACCUM) && bus.prod_valid;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (start) nxt = (len != '0) ? ACCUM : DONE;
            ACCUM:   if (xfer && remaining == LEN_W'(1)) nxt = DONE;
            DONE:    if (bus.acc_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.prod_ready = state == ACCUM;
        bus.acc_valid  = state == DONE;
        bus.Acc        = acc;
        busy           = state != IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            overflow  <= 1'b0;
            remaining <= '0;
        end else if (state == IDLE && start) begin
            acc       <= '0;
            overflow  <= 1'b0;
            remaining <= len;
        end else if (xfer) begin
            acc       <= sum;
            overflow  <= overflow | carry;
            remaining <= remaining - LEN_W'(1);
        end
    end
endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: directed scoreboard bench for mac_accumulator (24-bit and 16-bit instances)
module tb_mac_accumulator;
    typedef struct packed {
        logic        ovf;
        logic [23:0] acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, start16 = 1'b0;
    logic [7:0] len = '0, len16 = '0;
    logic       busy, overflow, busy16, overflow16;
    int         total = 0, bad = 0;
    exp_t       q24[$], q16[$];

    mac_accumulator_if #(.ACC_W(24)) bus24 ();
    mac_accumulator_if #(.ACC_W(16)) bus16 ();

    mac_accumulator #(.ACC_W(24), .LEN_W(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .bus(bus24), .busy(busy), .overflow(overflow)
    );
    mac_accumulator #(.ACC_W(16), .LEN_W(8)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .len(len16), .bus(bus16), .busy(busy16), .overflow(overflow16)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // monitors compare every cycle the result is presented, so a held result is checked for stability
    always @(negedge clk) begin
        if (!rst && bus24.acc_valid) begin
            if (q24.size() == 0) chk("unexpected_result24", 32'(bus24.Acc), 32'hdead);
            else begin
                chk("acc24", 32'(bus24.Acc), 32'(q24[0].acc));
                chk("ovf24", 32'(overflow), 32'(q24[0].ovf));
                if (bus24.acc_ready) void'(q24.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus16.acc_valid) begin
            if (q16.size() == 0) chk("unexpected_result16", 32'(bus16.Acc), 32'hdead);
            else begin
                chk("acc16", 32'(bus16.Acc), 32'(q16[0].acc));
                chk("ovf16", 32'(overflow16), 32'(q16[0].ovf));
                if (bus16.acc_ready) void'(q16.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus24.prod_valid = 0; bus24.Prod = '0; bus24.acc_ready = 0;
        bus16.prod_valid = 0; bus16.Prod = '0; bus16.acc_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("rst_acc_valid", 32'(bus24.acc_valid), 0);
        chk("rst_prod_ready", 32'(bus24.prod_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_acc", 32'(bus24.Acc), 0);
        chk("rst_ovf", 32'(overflow), 0);

        // three back-to-back max products
        start = 1; len = 3; q24.push_back('{1'b0, 24'd195075});
        cyc();
        start = 0;
        chk("t1_prod_ready", 32'(bus24.prod_ready), 1);
        chk("t1_busy", 32'(busy), 1);
        bus24.prod_valid = 1; bus24.Prod = 16'd65025; bus24.acc_ready = 1;
        cyc(); cyc();
        chk("t1_valid_early", 32'(bus24.acc_valid), 0);
        cyc();
        bus24.prod_valid = 0;
        chk("t1_valid_latency", 32'(bus24.acc_valid), 1);
        chk("t1_prod_ready_done", 32'(bus24.prod_ready), 0);
        cyc();
        chk("t1_idle_busy", 32'(busy), 0);
        chk("t1_idle_valid", 32'(bus24.acc_valid), 0);

        // empty sum
        chk("t2_no_ready_idle", 32'(bus24.prod_ready), 0);
        start = 1; len = 0; q24.push_back('{1'b0, 24'd0});
        cyc();
        start = 0;
        chk("t2_valid", 32'(bus24.acc_valid), 1);
        chk("t2_no_ready_done", 32'(bus24.prod_ready), 0);
        cyc();
        chk("t2_idle", 32'(busy), 0);

        // gap in products, result held under backpressure
        bus24.acc_ready = 0;
        start = 1; len = 2; q24.push_back('{1'b0, 24'd300});
        cyc();
        start = 0;
        bus24.prod_valid = 1; bus24.Prod = 16'd100;
        cyc();
        bus24.prod_valid = 0;
        cyc();
        chk("t3_gap_valid", 32'(bus24.acc_valid), 0);
        bus24.prod_valid = 1; bus24.Prod = 16'd200;
        cyc();
        bus24.prod_valid = 0;
        repeat (5) cyc();
        chk("t3_held_valid", 32'(bus24.acc_valid), 1);
        chk("t3_held_busy", 32'(busy), 1);
        bus24.acc_ready = 1;
        cyc();
        chk("t3_released", 32'(busy), 0);

        // reset mid-accumulation, then a fresh job
        start = 1; len = 4;
        cyc();
        start = 0;
        bus24.prod_valid = 1; bus24.Prod = 16'd50;
        cyc();
        bus24.prod_valid = 0; rst = 1;
        cyc();
        rst = 0;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_prod_ready", 32'(bus24.prod_ready), 0);
        chk("t5_acc", 32'(bus24.Acc), 0);
        chk("t5_valid", 32'(bus24.acc_valid), 0);
        start = 1; len = 1; q24.push_back('{1'b0, 24'd7});
        cyc();
        start = 0;
        bus24.prod_valid = 1; bus24.Prod = 16'd7;
        cyc();
        bus24.prod_valid = 0;
        cyc();

        // start while busy is ignored
        start = 1; len = 2; q24.push_back('{1'b0, 24'd30});
        cyc();
        len = 9;
        bus24.prod_valid = 1; bus24.Prod = 16'd10;
        cyc();
        bus24.Prod = 16'd20;
        cyc();
        start = 0; bus24.prod_valid = 0;
        chk("t6_done_after_2", 32'(bus24.acc_valid), 1);
        cyc();
        start = 1; len = 1; q24.push_back('{1'b0, 24'd5});
        cyc();
        start = 0;
        chk("t6_restart_busy", 32'(busy), 1);
        bus24.prod_valid = 1; bus24.Prod = 16'd5;
        cyc();
        bus24.prod_valid = 0;
        cyc();

        // 16-bit instance overflow, then overflow cleared by next start
        start16 = 1; len16 = 2;
`ifdef MAC_ACCUMULATOR_SATURATE_EN
        q16.push_back('{1'b1, 24'd65535});
`else
        q16.push_back('{1'b1, 24'd64514});
`endif
        cyc();
        start16 = 0;
        bus16.prod_valid = 1; bus16.Prod = 16'd65025; bus16.acc_ready = 1;
        cyc(); cyc();
        bus16.prod_valid = 0;
        chk("t4_ovf", 32'(overflow16), 1);
        chk("t4_valid", 32'(bus16.acc_valid), 1);
        cyc();
        start16 = 1; len16 = 1; q16.push_back('{1'b0, 24'd5});
        cyc();
        start16 = 0;
        chk("t4_ovf_cleared", 32'(overflow16), 0);
        bus16.prod_valid = 1; bus16.Prod = 16'd5;
        cyc();
        bus16.prod_valid = 0;
        repeat (3) cyc();

        chk("q24_drained", 32'(q24.size()), 0);
        chk("q16_drained", 32'(q16.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Downstream consumer of the 8x8 unsigned multiplier's 16-bit product stream.
- Sums a programmed number of products (dot-product style) into a registered wide accumulator.
- Presents the sum on a valid/ready result port.
- Sits between the multiplier functional unit and the writeback/result stage.

Parameters:
- ACC_W, 24, accumulator and result width in bits; must be >= 16.
- LEN_W, 8, width of the term-count input; at most 2^LEN_W-1 terms per operation.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a new accumulation; sampled only in IDLE
- len  input  LEN_W  number of products to sum; latched on accepted start
- prod_valid  input  1  Prod holds a valid product
- prod_ready  output  1  block accepts Prod this cycle
- Prod  input  16  unsigned product from the multiplier
- acc_valid  output  1  Acc holds the final sum
- acc_ready  input  1  consumer takes Acc
- Acc  output  ACC_W  accumulated sum (registered)
- busy  output  1  high in ACCUM or DONE
- overflow  output  1  sticky per operation; a carry out of ACC_W occurred

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state=IDLE, Acc=0, remaining=0, overflow=0, prod_ready=0, acc_valid=0, busy=0.
- rst high in any state, including mid-operation, returns to IDLE with all of the above cleared on that edge. A pending result is discarded.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - On start=1: Acc<=0, overflow<=0, remaining<=len.
  - Next state is ACCUM if len!=0, else DONE (empty sum gives Acc=0).
- ACCUM:
  - prod_ready=1 combinationally.
  - A transfer is prod_valid & prod_ready.
  - On a transfer: Acc<=Acc+Prod (zero-extended to ACC_W), remaining<=remaining-1.
  - When remaining==1 on a transfer, next state is DONE.
  - No transfer means hold. prod_valid gaps of any length are legal.
- DONE:
  - acc_valid=1, prod_ready=0. Acc and overflow are held stable.
  - On acc_ready=1, go to IDLE next cycle.
  - acc_ready low holds indefinitely; Acc must not change.
- Latency: acc_valid rises on the edge after the last product transfer. A back-to-back stream of N products takes N cycles in ACCUM.
- start while busy is ignored; len is not re-latched.
- Arithmetic: add computed at ACC_W+1 bits. The carry bit sets overflow (sticky until the next accepted start). Without saturation the result wraps mod 2^ACC_W.
- Prod is never registered upstream by this block; it is consumed in the same cycle as the transfer.

Optional Feature:
- Macro: MAC_ACCUMULATOR_SATURATE_EN.
- Defined:
  - On carry out, Acc<=all ones (2^ACC_W-1) and overflow<=1.
  - Further adds keep Acc at all ones.
- Undefined:
  - Acc wraps mod 2^ACC_W; overflow is still flagged.
- Port list is identical in both builds.

Decomposition:
- Shared header mac_defs.vh:
  - State encodings: IDLE=2'd0, ACCUM=2'd1, DONE=2'd2.
  - Default ACC_W and LEN_W localparams.
- Sub-module: acc_adder (ACC_W-bit add with carry out, optional saturate mux). This isolates the arithmetic so it can be swapped for the team's CLA-based adder later.
- FSM and counter stay in mac_accumulator.

Test Plan:
- len=3, Prod=65025 on three consecutive cycles with prod_valid=1, acc_ready=1 -> Acc=195075, overflow=0, acc_valid high exactly one cycle after the 3rd transfer, then IDLE.
- len=0 with start=1 -> DONE next cycle, Acc=0, acc_valid=1, no prod_ready pulse.
- len=2, Prod=100 then 200 with one idle cycle between, and acc_ready held low for 5 cycles -> Acc=300 stable throughout, acc_valid held, returns to IDLE only after acc_ready=1.
- ACC_W=16, len=2, Prod=65025 twice:
  - without macro -> Acc=64514, overflow=1;
  - with MAC_ACCUMULATOR_SATURATE_EN -> Acc=65535, overflow=1.
  - Next start clears overflow.
- Mid-ACCUM (1 of 4 terms taken) assert rst -> next cycle IDLE, Acc=0, busy=0, prod_ready=0. A subsequent len=1, Prod=7 gives Acc=7.
- start=1 with len=9 during ACCUM of a len=2 job -> ignored; job completes with 2 terms, and the next start in IDLE is honoured.
